mmio_uart_io: RTL

Parametrised memory-mapped I/O controller between the CPU load/store stage and the UART byte interface. It replaces direct, unbuffered UART register access with:
- independent TX and RX FIFOs of configurable depth;
- a sticky TX overflow flag;
- free-running cycle and retired-instruction counters.

The CPU reaches it through the `0x8xxxxxxx` I/O window. Read data has one-cycle latency, matching the data block RAM, so the writeback mux treats both sources identically.

---
 rtl/mmio_uart_io.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_io.sv
// rtl/mmio_uart_io.sv - memory-mapped UART controller with TX/RX FIFOs and cycle/instret counters
module mmio_uart_io #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8,
    parameter int CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  io_addr,
    input  logic        io_we,
    input  logic        io_re,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    input  logic        inst_retire,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;

    localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
    localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);

    localparam logic [2:0] A_TX_STAT = 3'd0;
    localparam logic [2:0] A_RX_STAT = 3'd1;
    localparam logic [2:0] A_RX_DATA = 3'd2;
    localparam logic [2:0] A_TX_DATA = 3'd3;
    localparam logic [2:0] A_CYCLE   = 3'd4;
    localparam logic [2:0] A_INSTRET = 3'd5;
    localparam logic [2:0] A_CLEAR   = 3'd6;
    localparam logic [2:0] A_LEVELS  = 3'd7;

    // Storage and state registers
    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [7:0]       rx_mem_q [RX_DEPTH];
    logic [TX_AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [TX_CW-1:0] tx_count_q, tx_count_d;
    logic [RX_AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RX_CW-1:0] rx_count_q, rx_count_d;
    logic             tx_ovf_q, tx_ovf_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
    logic [31:0]      rdata_q, rdata_d;

    // Decode and handshake qualifiers
    logic [2:0] sel;
    logic       wr_tx, wr_clr, rd_rx;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic       tx_drain, tx_push, tx_ovf_set;
    logic       rx_fill, rx_pop;
    logic [7:0] rx_head;

    assign sel      = io_addr[4:2];
    assign wr_tx    = io_we && (sel == A_TX_DATA);
    assign wr_clr   = io_we && (sel == A_CLEAR);
    assign rd_rx    = io_re && (sel == A_RX_DATA);

    assign tx_full  = (tx_count_q == TX_FULL_CNT);
    assign tx_empty = (tx_count_q == '0);
    assign rx_full  = (rx_count_q == RX_FULL_CNT);
    assign rx_empty = (rx_count_q == '0);

    // A drain in the same cycle frees a slot, so a store to a full FIFO is still taken
    assign tx_drain   = !tx_empty && tx_ready;
    assign tx_push    = wr_tx && (!tx_full || tx_drain);
    assign tx_ovf_set = wr_tx && tx_full && !tx_drain;

    assign rx_fill  = rx_valid && !rx_full;
    assign rx_pop   = rd_rx && !rx_empty;
    assign rx_head  = rx_mem_q[rx_rptr_q];

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_mem_q[tx_rptr_q];
    assign rx_ready = !rx_full;
    assign io_rdata = rdata_q;

    // Address bits outside [4:2] and the upper store data are deliberately ignored
    logic unused_ok;
    assign unused_ok = ^{io_addr[7:5], io_addr[1:0], io_wdata[31:8]};

    // TX FIFO pointer and occupancy update
    always_comb begin
        tx_wptr_d  = tx_wptr_q;
        tx_rptr_d  = tx_rptr_q;
        tx_count_d = tx_count_q;
        if (tx_push) begin
            tx_wptr_d = tx_wptr_q + TX_AW'(1);
        end
        if (tx_drain) begin
            tx_rptr_d = tx_rptr_q + TX_AW'(1);
        end
        case ({tx_push, tx_drain})
            2'b10:   tx_count_d = tx_count_q + TX_CW'(1);
            2'b01:   tx_count_d = tx_count_q - TX_CW'(1);
            default: tx_count_d = tx_count_q;
        endcase
    end

    // RX FIFO pointer and occupancy update
    always_comb begin
        rx_wptr_d  = rx_wptr_q;
        rx_rptr_d  = rx_rptr_q;
        rx_count_d = rx_count_q;
        if (rx_fill) begin
            rx_wptr_d = rx_wptr_q + RX_AW'(1);
        end
        if (rx_pop) begin
            rx_rptr_d = rx_rptr_q + RX_AW'(1);
        end
        case ({rx_fill, rx_pop})
            2'b10:   rx_count_d = rx_count_q + RX_CW'(1);
            2'b01:   rx_count_d = rx_count_q - RX_CW'(1);
            default: rx_count_d = rx_count_q;
        endcase
    end

    // Counters and sticky overflow; a clear store wins over a same-cycle increment
    always_comb begin
        tx_ovf_d    = tx_ovf_q | tx_ovf_set;
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        inst_cnt_d  = inst_retire ? (inst_cnt_q + CNT_W'(1)) : inst_cnt_q;
        if (wr_clr) begin
            tx_ovf_d    = 1'b0;
            cycle_cnt_d = '0;
            inst_cnt_d  = '0;
        end
    end

    // Load data mux; sampled from pre-edge state and held until the next load
    always_comb begin
        rdata_d = rdata_q;
        if (io_re) begin
            case (sel)
                A_TX_STAT: rdata_d = {30'b0, tx_ovf_q, !tx_full};
                A_RX_STAT: rdata_d = {31'b0, !rx_empty};
                A_RX_DATA: rdata_d = rx_empty ? 32'b0 : {24'b0, rx_head};
                A_CYCLE:   rdata_d = 32'(cycle_cnt_q);
                A_INSTRET: rdata_d = 32'(inst_cnt_q);
                A_LEVELS:  rdata_d = {16'(rx_count_q), 16'(tx_count_q)};
                default:   rdata_d = 32'b0;
            endcase
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            tx_count_q  <= '0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            rx_count_q  <= '0;
            tx_ovf_q    <= 1'b0;
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
            rdata_q     <= '0;
        end else begin
            tx_wptr_q   <= tx_wptr_d;
            tx_rptr_q   <= tx_rptr_d;
            tx_count_q  <= tx_count_d;
            rx_wptr_q   <= rx_wptr_d;
            rx_rptr_q   <= rx_rptr_d;
            rx_count_q  <= rx_count_d;
            tx_ovf_q    <= tx_ovf_d;
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
            rdata_q     <= rdata_d;
        end
    end

    // FIFO data arrays; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wptr_q] <= io_wdata[7:0];
        end
        if (rx_fill) begin
            rx_mem_q[rx_wptr_q] <= rx_data;
        end
    end

endmodule
